// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the lockstep recovery sequencer.
//   setback_state_e : recovery sequencer states.
//   cnt_width()     : width of a counter that must hold 0..max_val.
package ibex_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    QUIESCE = 3'd1,
    SETBACK = 3'd2,
    RESUME  = 3'd3,
    FATAL   = 3'd4
  } setback_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/ibex_outstanding_cnt.sv
// ibex_outstanding_cnt: in-flight transaction counter for one monitored bus.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   req_i, gnt_i      : an accepted request (req & gnt) opens a transaction
//   rvalid_i          : a response closes a transaction
//   cnt_o             : registered outstanding count, saturating at 0 and MaxOutstanding
// ibex_outstanding_cnt_chk: assertion-only companion flagging over/underflow.
module ibex_outstanding_cnt_chk #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntW           = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  input logic            inc_i,
  input logic            dec_i,
  input logic [CntW-1:0] cnt_i
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  // A grant with no response while already full would be lost.
  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec_i && (cnt_i == CntMax)));

  // A response with nothing outstanding indicates a protocol error.
  underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && (cnt_i == '0)));

endmodule

module ibex_outstanding_cnt
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntW           = cnt_width(MaxOutstanding)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            gnt_i,
  input  logic            rvalid_i,
  output logic [CntW-1:0] cnt_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic            inc;
  logic            dec;
  logic [CntW-1:0] cnt_d;
  logic [CntW-1:0] cnt_q;

  assign inc   = req_i & gnt_i;
  assign dec   = rvalid_i;
  assign cnt_o = cnt_q;

  // Next count: open/close cancel out, and both ends saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (dec && !inc) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  ibex_outstanding_cnt_chk #(
    .MaxOutstanding(MaxOutstanding),
    .CntW          (CntW)
  ) u_chk (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(inc),
    .dec_i(dec),
    .cnt_i(cnt_q)
  );

endmodule

// File: rtl/ibex_setback_ctrl.sv
// ibex_setback_ctrl: recovery sequencer for the dual-lockstep Ibex pair.
// On a lockstep mismatch it gates fetch, drains both monitored buses, pulses
// setback for SetbackCycles cycles, then resumes. Major alerts, drain timeouts
// and exhausted retries end in a sticky FATAL state left only by reset.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   fetch_enable_i               : SoC fetch enable
//   mismatch_i, alert_major_i    : lockstep error, major alert
//   rvfi_valid_i                 : master core retirement strobe
//   instr_/data_ req/gnt/rvalid  : monitored master-core buses
//   fetch_enable_o, setback_o    : to both cores (registered)
//   busy_o, fatal_o, retry_cnt_o : status (registered)
module ibex_setback_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SetbackCycles  = 4,
  parameter int unsigned MaxRetries     = 3,
  parameter int unsigned DrainTimeout   = 64,
  parameter int unsigned CleanRetire    = 16,
  parameter int unsigned RetryW         = cnt_width(MaxRetries)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_enable_i,
  input  logic              mismatch_i,
  input  logic              alert_major_i,
  input  logic              rvfi_valid_i,
  input  logic              instr_req_i,
  input  logic              instr_gnt_i,
  input  logic              instr_rvalid_i,
  input  logic              data_req_i,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic              fetch_enable_o,
  output logic              setback_o,
  output logic              busy_o,
  output logic              fatal_o,
  output logic [RetryW-1:0] retry_cnt_o
);

  localparam int unsigned CntW   = cnt_width(MaxOutstanding);
  localparam int unsigned DrainW = cnt_width(DrainTimeout);
  localparam int unsigned SbW    = cnt_width(SetbackCycles);
  localparam int unsigned CleanW = cnt_width(CleanRetire);

  localparam logic [RetryW-1:0] RetryMax   = RetryW'(MaxRetries);
  localparam logic [DrainW-1:0] DrainLimit = DrainW'(DrainTimeout);
  localparam logic [SbW-1:0]    SbLast     = SbW'(SetbackCycles - 32'd1);
  localparam logic [CleanW-1:0] CleanLast  = CleanW'(CleanRetire - 32'd1);

  setback_state_e    state_q, state_d, fsm_next;
  logic [CntW-1:0]   instr_cnt, data_cnt;
  logic              buses_idle;
  logic              stay;
  logic              clean_clear;
  logic [DrainW-1:0] drain_d, drain_q;
  logic [SbW-1:0]    sb_d, sb_q;
  logic [CleanW-1:0] clean_d, clean_q;
  logic [RetryW-1:0] retry_d, retry_q;
  logic              fe_d, fe_q;
  logic              setback_d, setback_q;
  logic              busy_d, busy_q;
  logic              fatal_d, fatal_q;

  ibex_outstanding_cnt #(
    .MaxOutstanding(MaxOutstanding),
    .CntW          (CntW)
  ) u_instr_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (instr_req_i),
    .gnt_i   (instr_gnt_i),
    .rvalid_i(instr_rvalid_i),
    .cnt_o   (instr_cnt)
  );

  ibex_outstanding_cnt #(
    .MaxOutstanding(MaxOutstanding),
    .CntW          (CntW)
  ) u_data_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (data_req_i),
    .gnt_i   (data_gnt_i),
    .rvalid_i(data_rvalid_i),
    .cnt_o   (data_cnt)
  );

  assign buses_idle = (instr_cnt == '0) && (data_cnt == '0);

  // Next state; a major alert overrides every other transition.
  always_comb begin
    fsm_next = state_q;
    case (state_q)
      RUN: begin
        if (mismatch_i) begin
          if (retry_q >= RetryMax) begin
            fsm_next = FATAL;
          end else begin
            fsm_next = QUIESCE;
          end
        end else begin
          fsm_next = RUN;
        end
      end
      QUIESCE: begin
        // A completed drain wins over a timeout expiring in the same cycle.
        if (buses_idle) begin
          fsm_next = SETBACK;
        end else if (drain_q == DrainLimit) begin
          fsm_next = FATAL;
        end else begin
          fsm_next = QUIESCE;
        end
      end
      SETBACK: begin
        if (sb_q == SbLast) begin
          fsm_next = RESUME;
        end else begin
          fsm_next = SETBACK;
        end
      end
      RESUME:  fsm_next = RUN;
      FATAL:   fsm_next = FATAL;
      default: fsm_next = FATAL;
    endcase
    if (alert_major_i) begin
      state_d = FATAL;
    end else begin
      state_d = fsm_next;
    end
  end

  // Timers, clean-retire counter and retry count; all timers restart on any state change.
  always_comb begin
    stay        = (state_d == state_q);
    clean_clear = 1'b0;
    drain_d     = '0;
    sb_d        = '0;
    clean_d     = '0;
    retry_d     = retry_q;

    if (stay && (state_q == QUIESCE)) begin
      if (drain_q != DrainLimit) begin
        drain_d = drain_q + DrainW'(1);
      end else begin
        drain_d = drain_q;
      end
    end else begin
      drain_d = '0;
    end

    if (stay && (state_q == SETBACK)) begin
      sb_d = sb_q + SbW'(1);
    end else begin
      sb_d = '0;
    end

    if (stay && (state_q == RUN) && !mismatch_i && rvfi_valid_i) begin
      if (clean_q >= CleanLast) begin
        clean_d     = '0;
        clean_clear = 1'b1;
      end else begin
        clean_d = clean_q + CleanW'(1);
      end
    end else if (stay && (state_q == RUN) && !mismatch_i) begin
      clean_d = clean_q;
    end else begin
      clean_d = '0;
    end

    if ((state_q == RESUME) && (state_d == RUN)) begin
      if (retry_q != RetryMax) begin
        retry_d = retry_q + RetryW'(1);
      end else begin
        retry_d = retry_q;
      end
    end else if (clean_clear) begin
      retry_d = '0;
    end else begin
      retry_d = retry_q;
    end
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    fe_d      = (state_d == RUN) && fetch_enable_i;
    setback_d = (state_d == SETBACK);
    busy_d    = (state_d == QUIESCE) || (state_d == SETBACK) || (state_d == RESUME);
    fatal_d   = (state_d == FATAL);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      drain_q   <= '0;
      sb_q      <= '0;
      clean_q   <= '0;
      retry_q   <= '0;
      fe_q      <= 1'b0;
      setback_q <= 1'b0;
      busy_q    <= 1'b0;
      fatal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      sb_q      <= sb_d;
      clean_q   <= clean_d;
      retry_q   <= retry_d;
      fe_q      <= fe_d;
      setback_q <= setback_d;
      busy_q    <= busy_d;
      fatal_q   <= fatal_d;
    end
  end

  assign fetch_enable_o = fe_q;
  assign setback_o      = setback_q;
  assign busy_o         = busy_q;
  assign fatal_o        = fatal_q;
  assign retry_cnt_o    = retry_q;

endmodule

// File: tb/tb_ibex_setback_ctrl.sv
// Testbench for ibex_setback_ctrl: scoreboard against a behavioural model,
// directed scenarios followed by randomized traffic.
module tb_ibex_setback_ctrl;

  localparam int MO = 2;
  localparam int SB = 4;
  localparam int MR = 3;
  localparam int DT = 64;
  localparam int CR = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, fe_i, mm, al, rv, ir, ig, iv, dr, dg, dv;
  logic fe_o, sb_o, busy_o, fatal_o;
  logic [1:0] retry_o;

  ibex_setback_ctrl dut (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(fe_i), .mismatch_i(mm),
    .alert_major_i(al), .rvfi_valid_i(rv),
    .instr_req_i(ir), .instr_gnt_i(ig), .instr_rvalid_i(iv),
    .data_req_i(dr), .data_gnt_i(dg), .data_rvalid_i(dv),
    .fetch_enable_o(fe_o), .setback_o(sb_o), .busy_o(busy_o),
    .fatal_o(fatal_o), .retry_cnt_o(retry_o)
  );

  typedef struct packed {
    logic rst, fe, mm, al, rv, ir, ig, iv, dr, dg, dv;
  } stim_t;

  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: recovery described as "draining / pulses left / resuming".
  int m_ic, m_dc, m_pulse, m_wait, m_clean, m_retry;
  bit m_fatal, m_drain, m_resume;

  function automatic int bus_next(int c, bit inc, bit dec);
    if (inc && !dec) return (c < MO) ? c + 1 : c;
    if (dec && !inc) return (c > 0) ? c - 1 : c;
    return c;
  endfunction

  function automatic logic [5:0] model_step(stim_t s);
    int ic_now = m_ic;
    int dc_now = m_dc;
    bit run;
    logic [1:0] r;
    if (s.rst) begin
      m_ic = 0; m_dc = 0; m_pulse = 0; m_wait = 0; m_clean = 0; m_retry = 0;
      m_fatal = 0; m_drain = 0; m_resume = 0;
      return 6'b0;
    end
    m_ic = bus_next(m_ic, s.ir && s.ig, s.iv);
    m_dc = bus_next(m_dc, s.dr && s.dg, s.dv);
    if (m_fatal) begin
      m_fatal = 1;
    end else if (s.al) begin
      m_fatal = 1; m_drain = 0; m_pulse = 0; m_resume = 0; m_clean = 0;
    end else if (m_drain) begin
      if (ic_now == 0 && dc_now == 0) begin
        m_drain = 0; m_pulse = SB;
      end else if (m_wait == DT) begin
        m_drain = 0; m_fatal = 1;
      end else begin
        m_wait++;
      end
    end else if (m_pulse > 0) begin
      if (m_pulse == 1) m_resume = 1;
      m_pulse--;
    end else if (m_resume) begin
      m_resume = 0; m_retry++; m_clean = 0;
    end else if (s.mm) begin
      m_clean = 0;
      if (m_retry >= MR) m_fatal = 1;
      else begin m_drain = 1; m_wait = 0; end
    end else if (s.rv) begin
      m_clean++;
      if (m_clean == CR) begin m_clean = 0; m_retry = 0; end
    end
    run = !m_fatal && !m_drain && (m_pulse == 0) && !m_resume;
    r = 2'(m_retry);
    return {run && s.fe, m_pulse > 0, m_drain || (m_pulse > 0) || m_resume, m_fatal, r};
  endfunction

  // Monitor: pops one expectation per clock and compares all outputs.
  initial begin
    logic [5:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {fe_o, sb_o, busy_o, fatal_o, retry_o};
        n_checks++;
        if (got === e) n_pass++;
        else $display("FAIL outputs t=%0t {fe,sb,busy,fatal,retry} got=%b expected=%b", $time, got, e);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp_v);
  endtask

  task automatic step(input stim_t s);
    rst = s.rst; fe_i = s.fe; mm = s.mm; al = s.al; rv = s.rv;
    ir = s.ir; ig = s.ig; iv = s.iv; dr = s.dr; dg = s.dg; dv = s.dv;
    exp_q.push_back(model_step(s));
    @(posedge clk);
    #2;
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.fe = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = '0;
    s.fe  = ($urandom_range(0, 9) != 0);
    s.mm  = ($urandom_range(0, 39) == 0);
    s.al  = ($urandom_range(0, 599) == 0);
    s.rv  = 1'($urandom_range(0, 1));
    s.ir  = 1'($urandom_range(0, 1));
    s.iv  = (m_ic > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    s.ig  = (m_ic < MO || s.iv) ? 1'($urandom_range(0, 1)) : 1'b0;
    s.dr  = 1'($urandom_range(0, 1));
    s.dv  = (m_dc > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    s.dg  = (m_dc < MO || s.dv) ? 1'($urandom_range(0, 1)) : 1'b0;
    s.rst = m_fatal && ($urandom_range(0, 15) == 0);
    return s;
  endfunction

  task automatic do_reset();
    stim_t s = idle();
    s.rst = 1'b1;
    repeat (2) step(s);
  endtask

  initial begin
    stim_t s;
    do_reset();
    check("reset_fe", fe_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_retry", retry_o, 0);

    // Empty buses recovery.
    repeat (10) step(idle());
    check("run_fe", fe_o, 1);
    s = idle(); s.mm = 1'b1; step(s);
    check("mm_fe", fe_o, 0);
    check("mm_busy", busy_o, 1);
    check("mm_sb", sb_o, 0);
    for (int k = 1; k <= 4; k++) begin
      step(idle());
      check("sb_pulse", sb_o, 1);
    end
    step(idle());
    check("resume_sb", sb_o, 0);
    check("resume_busy", busy_o, 1);
    step(idle());
    check("back_fe", fe_o, 1);
    check("back_busy", busy_o, 0);
    check("retry_one", retry_o, 1);

    // Retry clear after CleanRetire retirements.
    s = idle(); s.rv = 1'b1;
    repeat (15) step(s);
    check("clean15_retry", retry_o, 1);
    step(s);
    check("clean16_retry", retry_o, 0);

    // Drain: two instruction grants, responses at +5 and +9.
    s = idle(); s.ir = 1'b1; s.ig = 1'b1;
    repeat (2) step(s);
    s = idle(); s.mm = 1'b1; step(s);
    for (int i = 1; i <= 9; i++) begin
      s = idle(); s.iv = (i == 5 || i == 9); step(s);
      check("drain_no_sb", sb_o, 0);
    end
    step(idle());
    check("drain_sb_start", sb_o, 1);
    repeat (6) step(idle());

    // Retry limit: three recoveries, the fourth mismatch is fatal.
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      s = idle(); s.mm = 1'b1; step(s);
      for (int j = 0; j < 7; j++) begin
        s = idle(); s.rv = (j > 4); step(s);
      end
      check("limit_fatal", fatal_o, (n == 4) ? 1 : 0);
      check("limit_retry", retry_o, (n == 4) ? 3 : n);
    end
    s = idle(); s.mm = 1'b1;
    repeat (3) step(s);
    check("fatal_sticky", fatal_o, 1);
    check("fatal_fe", fe_o, 0);

    // Drain timeout: one data grant never answered.
    do_reset();
    step(idle());
    s = idle(); s.dr = 1'b1; s.dg = 1'b1; step(s);
    s = idle(); s.mm = 1'b1; step(s);
    repeat (64) step(idle());
    check("timeout_not_yet", fatal_o, 0);
    step(idle());
    check("timeout_fatal", fatal_o, 1);
    repeat (5) step(idle());
    check("timeout_fe", fe_o, 0);
    do_reset();
    check("post_reset_fatal", fatal_o, 0);

    // Alert on the second setback cycle.
    step(idle());
    s = idle(); s.mm = 1'b1; step(s);
    repeat (2) step(idle());
    check("alert_pre_sb", sb_o, 1);
    s = idle(); s.al = 1'b1; step(s);
    check("alert_sb", sb_o, 0);
    check("alert_fatal", fatal_o, 1);
    do_reset();

    // Simultaneous grant and response leaves the count unchanged.
    s = idle(); s.ir = 1'b1; s.ig = 1'b1; step(s);
    s.iv = 1'b1; step(s);
    s = idle(); s.mm = 1'b1; step(s);
    repeat (3) step(idle());
    check("both_still_drain", sb_o, 0);
    s = idle(); s.iv = 1'b1; step(s);
    step(idle());
    check("both_sb_start", sb_o, 1);
    repeat (6) step(idle());

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) step(rand_stim());
    step(idle());
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
